// File: rtl/sort_pkg.sv
// sort_pkg: shared defaults and FSM state encoding for the sort register file pipeline
package sort_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 3;
    localparam int DEF_DEPTH = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t FETCH   = 3'd1;
    localparam state_t PRESENT = 3'd2;
    localparam state_t SETTLE  = 3'd3;
    localparam state_t DONE    = 3'd4;

endpackage

// File: rtl/sort_pair_addr_gen.sv
// sort_pair_addr_gen: pair index and pass counters with last-pair / last-pass flags
module sort_pair_addr_gen #(
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          next_idx,
    input  logic          next_pass,
    output logic [AW-1:0] idx,
    output logic          last_pair,
    output logic          last_pass
);

    logic [AW-1:0] pass;

    // idx walks 0..DEPTH-2 within a pass; a new pass rewinds idx and bumps the pass count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            pass <= '0;
        end else if (clear) begin
            idx  <= '0;
            pass <= '0;
        end else if (next_pass) begin
            idx  <= '0;
            pass <= pass + {{(AW-1){1'b0}}, 1'b1};
        end else if (next_idx) begin
            idx <= idx + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    assign last_pair = idx == AW'(DEPTH - 2);
    assign last_pass = pass == AW'(DEPTH - 2);

endmodule

// File: rtl/sort_pair_reader.sv
// sort_pair_reader: bubble-sort read sequencer; optional swap counter under SORT_STATS_EN
module sort_pair_reader
    import sort_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    input  logic [DW-1:0] rd_data1,
    input  logic [DW-1:0] rd_data2,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic          pair_valid,
    input  logic          pair_ready,
    input  logic          swap,
    output logic          busy,
    output logic          done
`ifdef SORT_STATS_EN
    ,
    output logic [7:0]    swap_cnt
`endif
);

    state_t        state, nxt;
    logic          swapped, accept, hs, next_idx, next_pass, last_pair, last_pass;
    logic [AW-1:0] idx;
    logic [AW:0]   idx_p1;

    assign accept     = state == IDLE && start;
    assign hs         = state == PRESENT && pair_ready;
    assign next_idx   = state == SETTLE && !last_pair;
    assign next_pass  = state == SETTLE && last_pair && swapped && !last_pass;
    assign idx_p1     = {1'b0, idx} + {{AW{1'b0}}, 1'b1};
    assign rd_addr1   = idx;
    assign rd_addr2   = idx_p1[AW-1:0];
    assign pair_valid = state == PRESENT;
    assign busy       = state != IDLE;
    assign done       = state == DONE;

    sort_pair_addr_gen #(.AW(AW), .DEPTH(DEPTH)) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .next_idx  (next_idx),
        .next_pass (next_pass),
        .idx       (idx),
        .last_pair (last_pair),
        .last_pass (last_pass)
    );

    // next state: SETTLE returns to FETCH unless the final pair of the final pass was handled
    always_comb begin
        nxt = state == IDLE    ? (start ? FETCH : IDLE) :
              state == FETCH   ? PRESENT :
              state == PRESENT ? (pair_ready ? SETTLE : PRESENT) :
              state == SETTLE  ? ((next_idx || next_pass) ? FETCH : DONE) :
                                 IDLE;
    end

    // state register, pass swap flag and the A/B pair captured from the read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            swapped <= 1'b0;
            A       <= '0;
            B       <= '0;
        end else begin
            state   <= nxt;
            swapped <= (accept || next_pass) ? 1'b0 : (hs ? (swapped | swap) : swapped);
            if (state == FETCH) begin
                A <= rd_data1;
                B <= rd_data2;
            end
        end
    end

`ifdef SORT_STATS_EN
    // saturating count of swapped pairs, kept after DONE until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            swap_cnt <= 8'h00;
        else if (accept)
            swap_cnt <= 8'h00;
        else if (hs && swap && swap_cnt != 8'hFF)
            swap_cnt <= swap_cnt + 8'h01;
    end
`endif

endmodule

// File: tb/tb_sort_pair_reader.sv
// tb_sort_pair_reader: scoreboard bench with a register-file and writer model for sort_pair_reader
module tb_sort_pair_reader;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pair_ready = 1'b0;
    logic          swap = 1'b0;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2, A, B;
    logic          pair_valid, busy, done;
`ifdef SORT_STATS_EN
    logic [7:0]    swap_cnt;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] fin [DEPTH];
    pair_t         q[$];
    int            vectors = 0;
    int            errors = 0;
    int            exp_pairs, exp_swaps;

    always #5 clk = ~clk;

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

    sort_pair_reader #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .A          (A),
        .B          (B),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .swap       (swap),
        .busy       (busy),
        .done       (done)
`ifdef SORT_STATS_EN
        ,
        .swap_cnt   (swap_cnt)
`endif
    );

    function automatic logic decide(input int policy, input logic [DW-1:0] a, input logic [DW-1:0] b);
        return policy == 1 ? 1'b1 : (a > b);
    endfunction

    // reference bubble sort with the DEPTH-1 pass cap; fills the scoreboard and final image
    task automatic build_model(input int policy);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] t;
        pair_t e;
        bit sw;
        q.delete();
        exp_pairs = 0;
        exp_swaps = 0;
        for (int k = 0; k < DEPTH; k++) m[k] = mem[k];
        for (int p = 0; p < DEPTH; p++) begin
            sw = 0;
            for (int i = 0; i < DEPTH - 1; i++) begin
                e.a = AW'(i);
                e.x = m[i];
                e.y = m[i+1];
                q.push_back(e);
                exp_pairs++;
                if (decide(policy, m[i], m[i+1])) begin
                    t = m[i]; m[i] = m[i+1]; m[i+1] = t;
                    sw = 1;
                    exp_swaps++;
                end
            end
            if (!(sw && p < DEPTH - 2)) break;
        end
        for (int k = 0; k < DEPTH; k++) fin[k] = m[k];
    endtask

    task automatic run_sort(input string name, input int policy, input int stall, input bit noise, input int exp_edges);
        int edges, pairs, st;
        bit hs, bad;
        pair_t e;
        logic [AW-1:0] wa;
        logic [DW-1:0] wx, wy;
        build_model(policy);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        pairs = 0;
        st = stall;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) break;
            hs = 0;
            start = noise ? 1'($urandom % 2) : 1'b0;
            if (pair_valid) begin
                e = q.size() != 0 ? q[0] : '0;
                vectors++;
                if (q.size() == 0 || A !== e.x || B !== e.y || rd_addr1 !== e.a || rd_addr2 !== AW'(e.a + 1)) begin
                    errors++;
                    $display("FAIL %s pair%0d: got addr=%0d A=%h B=%h, expected addr=%0d A=%h B=%h",
                             name, pairs, rd_addr1, A, B, e.a, e.x, e.y);
                end
                if (st > 0) begin
                    pair_ready = 1'b0;
                    swap = noise | (policy == 1);
                    st--;
                end else begin
                    pair_ready = 1'b1;
                    swap = decide(policy, A, B);
                    hs = 1;
                    wa = rd_addr1; wx = A; wy = B;
                end
            end else begin
                pair_ready = noise ? 1'($urandom % 2) : 1'b0;
                swap = noise | (policy == 1);
            end
            @(posedge clk);
            edges++;
            if (hs) begin
                if (q.size() != 0) void'(q.pop_front());
                pairs++;
                st = stall;
                if (swap) begin
                    #1;
                    mem[wa] = wy;
                    mem[wa+1] = wx;
                end
            end
        end
        start = 1'b0;
        pair_ready = 1'b0;
        swap = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: got done=%b busy=%b, expected done=1 busy=1", name, done, busy);
        end
        if (exp_edges > 0) begin
            vectors++;
            if (edges !== exp_edges) begin
                errors++;
                $display("FAIL %s done_latency: got %0d edges, expected %0d", name, edges, exp_edges);
            end
        end
        vectors++;
        if (pairs !== exp_pairs || q.size() != 0) begin
            errors++;
            $display("FAIL %s pair_count: got %0d pairs (%0d left), expected %0d", name, pairs, q.size(), exp_pairs);
        end
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== fin[k]) bad = 1;
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL %s final_file: got %h..%h, expected %h..%h", name, mem[0], mem[DEPTH-1], fin[0], fin[DEPTH-1]);
        end
`ifdef SORT_STATS_EN
        vectors++;
        if (swap_cnt !== 8'(exp_swaps)) begin
            errors++;
            $display("FAIL %s swap_cnt: got %0d, expected %0d", name, swap_cnt, exp_swaps);
        end
`endif
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b, expected done=0 busy=0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (pair_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || A !== '0 || B !== '0 ||
            rd_addr1 !== 3'd0 || rd_addr2 !== 3'd1) begin
            errors++;
            $display("FAIL reset_state: got pv=%b busy=%b done=%b A=%h B=%h a1=%0d a2=%0d, expected 0 0 0 0 0 0 1",
                     pair_valid, busy, done, A, B, rd_addr1, rd_addr2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(100 + k);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !(pair_valid && rd_addr1 == 3'd2); c++) begin
            pair_ready = pair_valid;
            @(negedge clk);
        end
        pair_ready = 1'b0;
        vectors++;
        if (pair_valid !== 1'b1 || A !== DW'(102)) begin
            errors++;
            $display("FAIL reset_reach_present: got pv=%b A=%h, expected pv=1 A=%h", pair_valid, A, DW'(102));
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pair_valid !== 1'b0 || busy !== 1'b0 || A !== '0 || B !== '0 || rd_addr1 !== 3'd0 || rd_addr2 !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_present: got pv=%b busy=%b A=%h B=%h a1=%0d a2=%0d, expected 0 0 0 0 0 1",
                     pair_valid, busy, A, B, rd_addr1, rd_addr2);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pair_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (pair_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_reissue: got pv=%b busy=%b, expected 0 0", pair_valid, busy);
        end
        pair_ready = 1'b0;
    endtask

    task automatic test_sorted();
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
        run_sort("sorted", 0, 0, 0, 22);
    endtask

    task automatic test_reverse();
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(DEPTH - 1 - k);
        run_sort("reverse", 0, 0, 0, -1);
        vectors++;
        if (exp_pairs !== 49 || exp_swaps !== 28) begin
            errors++;
            $display("FAIL reverse_model: got %0d pairs %0d swaps, expected 49 28", exp_pairs, exp_swaps);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        run_sort("backpressure", 0, 5, 0, -1);
    endtask

    task automatic test_ignore();
        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        run_sort("ignore", 0, 2, 1, -1);
    endtask

    task automatic test_stuck_swap();
        for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
        run_sort("stuck_swap", 1, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_sorted();
        test_reverse();
        test_backpressure();
        test_ignore();
        test_stuck_swap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
